byte_encrypt_core: RTL and testbench

Iterative 8-bit encryption engine for the byte cryptosystem. It accepts one plaintext byte and one 8-bit key over a valid/ready handshake. It runs ROUNDS rounds, each a key-XOR, a FIPS-197 S-box substitution and a rotate, and returns one ciphertext byte over a second valid/ready handshake. It sits between the plaintext source (UART RX / switch front-end) and the ciphertext sink, and it is the encrypt-side counterpart of the decrypt path built on the inverse substitution.

---
 rtl/byte_encrypt_core.sv | 131 +++++++++++++
 tb/tb_byte_encrypt_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/byte_encrypt_core.sv
// byte_encrypt_core: iterative 8-bit cipher (key-XOR, AES S-box, rotate per round)
// with valid/ready handshakes on the plaintext and ciphertext sides.
module byte_encrypt_core #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] key,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LAST_CNT = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t        state;
  logic [W-1:0]  x;
  logic [W-1:0]  rk;
  logic [CW-1:0] cnt;

  logic [W-1:0]  sbox_in;
  logic [W-1:0]  sbox_out;
  logic [W-1:0]  round_x;
  logic [W-1:0]  rk_next;
  logic [CW-1:0] cnt_inc;

  // Round datapath: key mix, substitution, rotate, and next round key.
  always_comb begin
    sbox_in = x ^ rk;
    round_x = {sbox_out[6:0], sbox_out[7]};
    cnt_inc = cnt + CW'(1);
    rk_next = {rk[4:0], rk[7:5]} ^ {4'h0, cnt_inc};
  end

  // FIPS-197 SubBytes table.
  always_comb begin
    sbox_out = 8'h00;
    case (sbox_in)
      8'h00: sbox_out = 8'h63; 8'h01: sbox_out = 8'h7c; 8'h02: sbox_out = 8'h77; 8'h03: sbox_out = 8'h7b; 8'h04: sbox_out = 8'hf2; 8'h05: sbox_out = 8'h6b; 8'h06: sbox_out = 8'h6f; 8'h07: sbox_out = 8'hc5;
      8'h08: sbox_out = 8'h30; 8'h09: sbox_out = 8'h01; 8'h0a: sbox_out = 8'h67; 8'h0b: sbox_out = 8'h2b; 8'h0c: sbox_out = 8'hfe; 8'h0d: sbox_out = 8'hd7; 8'h0e: sbox_out = 8'hab; 8'h0f: sbox_out = 8'h76;
      8'h10: sbox_out = 8'hca; 8'h11: sbox_out = 8'h82; 8'h12: sbox_out = 8'hc9; 8'h13: sbox_out = 8'h7d; 8'h14: sbox_out = 8'hfa; 8'h15: sbox_out = 8'h59; 8'h16: sbox_out = 8'h47; 8'h17: sbox_out = 8'hf0;
      8'h18: sbox_out = 8'had; 8'h19: sbox_out = 8'hd4; 8'h1a: sbox_out = 8'ha2; 8'h1b: sbox_out = 8'haf; 8'h1c: sbox_out = 8'h9c; 8'h1d: sbox_out = 8'ha4; 8'h1e: sbox_out = 8'h72; 8'h1f: sbox_out = 8'hc0;
      8'h20: sbox_out = 8'hb7; 8'h21: sbox_out = 8'hfd; 8'h22: sbox_out = 8'h93; 8'h23: sbox_out = 8'h26; 8'h24: sbox_out = 8'h36; 8'h25: sbox_out = 8'h3f; 8'h26: sbox_out = 8'hf7; 8'h27: sbox_out = 8'hcc;
      8'h28: sbox_out = 8'h34; 8'h29: sbox_out = 8'ha5; 8'h2a: sbox_out = 8'he5; 8'h2b: sbox_out = 8'hf1; 8'h2c: sbox_out = 8'h71; 8'h2d: sbox_out = 8'hd8; 8'h2e: sbox_out = 8'h31; 8'h2f: sbox_out = 8'h15;
      8'h30: sbox_out = 8'h04; 8'h31: sbox_out = 8'hc7; 8'h32: sbox_out = 8'h23; 8'h33: sbox_out = 8'hc3; 8'h34: sbox_out = 8'h18; 8'h35: sbox_out = 8'h96; 8'h36: sbox_out = 8'h05; 8'h37: sbox_out = 8'h9a;
      8'h38: sbox_out = 8'h07; 8'h39: sbox_out = 8'h12; 8'h3a: sbox_out = 8'h80; 8'h3b: sbox_out = 8'he2; 8'h3c: sbox_out = 8'heb; 8'h3d: sbox_out = 8'h27; 8'h3e: sbox_out = 8'hb2; 8'h3f: sbox_out = 8'h75;
      8'h40: sbox_out = 8'h09; 8'h41: sbox_out = 8'h83; 8'h42: sbox_out = 8'h2c; 8'h43: sbox_out = 8'h1a; 8'h44: sbox_out = 8'h1b; 8'h45: sbox_out = 8'h6e; 8'h46: sbox_out = 8'h5a; 8'h47: sbox_out = 8'ha0;
      8'h48: sbox_out = 8'h52; 8'h49: sbox_out = 8'h3b; 8'h4a: sbox_out = 8'hd6; 8'h4b: sbox_out = 8'hb3; 8'h4c: sbox_out = 8'h29; 8'h4d: sbox_out = 8'he3; 8'h4e: sbox_out = 8'h2f; 8'h4f: sbox_out = 8'h84;
      8'h50: sbox_out = 8'h53; 8'h51: sbox_out = 8'hd1; 8'h52: sbox_out = 8'h00; 8'h53: sbox_out = 8'hed; 8'h54: sbox_out = 8'h20; 8'h55: sbox_out = 8'hfc; 8'h56: sbox_out = 8'hb1; 8'h57: sbox_out = 8'h5b;
      8'h58: sbox_out = 8'h6a; 8'h59: sbox_out = 8'hcb; 8'h5a: sbox_out = 8'hbe; 8'h5b: sbox_out = 8'h39; 8'h5c: sbox_out = 8'h4a; 8'h5d: sbox_out = 8'h4c; 8'h5e: sbox_out = 8'h58; 8'h5f: sbox_out = 8'hcf;
      8'h60: sbox_out = 8'hd0; 8'h61: sbox_out = 8'hef; 8'h62: sbox_out = 8'haa; 8'h63: sbox_out = 8'hfb; 8'h64: sbox_out = 8'h43; 8'h65: sbox_out = 8'h4d; 8'h66: sbox_out = 8'h33; 8'h67: sbox_out = 8'h85;
      8'h68: sbox_out = 8'h45; 8'h69: sbox_out = 8'hf9; 8'h6a: sbox_out = 8'h02; 8'h6b: sbox_out = 8'h7f; 8'h6c: sbox_out = 8'h50; 8'h6d: sbox_out = 8'h3c; 8'h6e: sbox_out = 8'h9f; 8'h6f: sbox_out = 8'ha8;
      8'h70: sbox_out = 8'h51; 8'h71: sbox_out = 8'ha3; 8'h72: sbox_out = 8'h40; 8'h73: sbox_out = 8'h8f; 8'h74: sbox_out = 8'h92; 8'h75: sbox_out = 8'h9d; 8'h76: sbox_out = 8'h38; 8'h77: sbox_out = 8'hf5;
      8'h78: sbox_out = 8'hbc; 8'h79: sbox_out = 8'hb6; 8'h7a: sbox_out = 8'hda; 8'h7b: sbox_out = 8'h21; 8'h7c: sbox_out = 8'h10; 8'h7d: sbox_out = 8'hff; 8'h7e: sbox_out = 8'hf3; 8'h7f: sbox_out = 8'hd2;
      8'h80: sbox_out = 8'hcd; 8'h81: sbox_out = 8'h0c; 8'h82: sbox_out = 8'h13; 8'h83: sbox_out = 8'hec; 8'h84: sbox_out = 8'h5f; 8'h85: sbox_out = 8'h97; 8'h86: sbox_out = 8'h44; 8'h87: sbox_out = 8'h17;
      8'h88: sbox_out = 8'hc4; 8'h89: sbox_out = 8'ha7; 8'h8a: sbox_out = 8'h7e; 8'h8b: sbox_out = 8'h3d; 8'h8c: sbox_out = 8'h64; 8'h8d: sbox_out = 8'h5d; 8'h8e: sbox_out = 8'h19; 8'h8f: sbox_out = 8'h73;
      8'h90: sbox_out = 8'h60; 8'h91: sbox_out = 8'h81; 8'h92: sbox_out = 8'h4f; 8'h93: sbox_out = 8'hdc; 8'h94: sbox_out = 8'h22; 8'h95: sbox_out = 8'h2a; 8'h96: sbox_out = 8'h90; 8'h97: sbox_out = 8'h88;
      8'h98: sbox_out = 8'h46; 8'h99: sbox_out = 8'hee; 8'h9a: sbox_out = 8'hb8; 8'h9b: sbox_out = 8'h14; 8'h9c: sbox_out = 8'hde; 8'h9d: sbox_out = 8'h5e; 8'h9e: sbox_out = 8'h0b; 8'h9f: sbox_out = 8'hdb;
      8'ha0: sbox_out = 8'he0; 8'ha1: sbox_out = 8'h32; 8'ha2: sbox_out = 8'h3a; 8'ha3: sbox_out = 8'h0a; 8'ha4: sbox_out = 8'h49; 8'ha5: sbox_out = 8'h06; 8'ha6: sbox_out = 8'h24; 8'ha7: sbox_out = 8'h5c;
      8'ha8: sbox_out = 8'hc2; 8'ha9: sbox_out = 8'hd3; 8'haa: sbox_out = 8'hac; 8'hab: sbox_out = 8'h62; 8'hac: sbox_out = 8'h91; 8'had: sbox_out = 8'h95; 8'hae: sbox_out = 8'he4; 8'haf: sbox_out = 8'h79;
      8'hb0: sbox_out = 8'he7; 8'hb1: sbox_out = 8'hc8; 8'hb2: sbox_out = 8'h37; 8'hb3: sbox_out = 8'h6d; 8'hb4: sbox_out = 8'h8d; 8'hb5: sbox_out = 8'hd5; 8'hb6: sbox_out = 8'h4e; 8'hb7: sbox_out = 8'ha9;
      8'hb8: sbox_out = 8'h6c; 8'hb9: sbox_out = 8'h56; 8'hba: sbox_out = 8'hf4; 8'hbb: sbox_out = 8'hea; 8'hbc: sbox_out = 8'h65; 8'hbd: sbox_out = 8'h7a; 8'hbe: sbox_out = 8'hae; 8'hbf: sbox_out = 8'h08;
      8'hc0: sbox_out = 8'hba; 8'hc1: sbox_out = 8'h78; 8'hc2: sbox_out = 8'h25; 8'hc3: sbox_out = 8'h2e; 8'hc4: sbox_out = 8'h1c; 8'hc5: sbox_out = 8'ha6; 8'hc6: sbox_out = 8'hb4; 8'hc7: sbox_out = 8'hc6;
      8'hc8: sbox_out = 8'he8; 8'hc9: sbox_out = 8'hdd; 8'hca: sbox_out = 8'h74; 8'hcb: sbox_out = 8'h1f; 8'hcc: sbox_out = 8'h4b; 8'hcd: sbox_out = 8'hbd; 8'hce: sbox_out = 8'h8b; 8'hcf: sbox_out = 8'h8a;
      8'hd0: sbox_out = 8'h70; 8'hd1: sbox_out = 8'h3e; 8'hd2: sbox_out = 8'hb5; 8'hd3: sbox_out = 8'h66; 8'hd4: sbox_out = 8'h48; 8'hd5: sbox_out = 8'h03; 8'hd6: sbox_out = 8'hf6; 8'hd7: sbox_out = 8'h0e;
      8'hd8: sbox_out = 8'h61; 8'hd9: sbox_out = 8'h35; 8'hda: sbox_out = 8'h57; 8'hdb: sbox_out = 8'hb9; 8'hdc: sbox_out = 8'h86; 8'hdd: sbox_out = 8'hc1; 8'hde: sbox_out = 8'h1d; 8'hdf: sbox_out = 8'h9e;
      8'he0: sbox_out = 8'he1; 8'he1: sbox_out = 8'hf8; 8'he2: sbox_out = 8'h98; 8'he3: sbox_out = 8'h11; 8'he4: sbox_out = 8'h69; 8'he5: sbox_out = 8'hd9; 8'he6: sbox_out = 8'h8e; 8'he7: sbox_out = 8'h94;
      8'he8: sbox_out = 8'h9b; 8'he9: sbox_out = 8'h1e; 8'hea: sbox_out = 8'h87; 8'heb: sbox_out = 8'he9; 8'hec: sbox_out = 8'hce; 8'hed: sbox_out = 8'h55; 8'hee: sbox_out = 8'h28; 8'hef: sbox_out = 8'hdf;
      8'hf0: sbox_out = 8'h8c; 8'hf1: sbox_out = 8'ha1; 8'hf2: sbox_out = 8'h89; 8'hf3: sbox_out = 8'h0d; 8'hf4: sbox_out = 8'hbf; 8'hf5: sbox_out = 8'he6; 8'hf6: sbox_out = 8'h42; 8'hf7: sbox_out = 8'h68;
      8'hf8: sbox_out = 8'h41; 8'hf9: sbox_out = 8'h99; 8'hfa: sbox_out = 8'h2d; 8'hfb: sbox_out = 8'h0f; 8'hfc: sbox_out = 8'hb0; 8'hfd: sbox_out = 8'h54; 8'hfe: sbox_out = 8'hbb; 8'hff: sbox_out = 8'h16;
      default: sbox_out = 8'h00;
    endcase
  end

  // Control FSM with registered handshake outputs; whitening folds into the last round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      busy      <= 1'b0;
      cnt       <= '0;
      x         <= '0;
      rk        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state    <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            x        <= in_data;
            rk       <= key;
            cnt      <= '0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ROUND: begin
          x   <= round_x;
          rk  <= rk_next;
          cnt <= cnt_inc;
          if (cnt == LAST_CNT) begin
            out_data  <= round_x ^ rk_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_encrypt_core.sv
// Directed bench for byte_encrypt_core: a ROUNDS=4 and a ROUNDS=1 instance share inputs.
module tb_byte_encrypt_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] key;
  logic       out_ready;

  logic       in_ready4, out_valid4, busy4;
  logic [7:0] out_data4;
  logic       in_ready1, out_valid1, busy1;
  logic [7:0] out_data1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] xs  [0:4];
  logic [7:0] rks [0:4];

  always #5 clk = ~clk;

  byte_encrypt_core #(.ROUNDS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .key(key), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .busy(busy4)
  );

  byte_encrypt_core #(.ROUNDS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .key(key), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one byte on both instances, then record latency and data of each ciphertext.
  task automatic run_vec(input logic [7:0] d, input logic [7:0] k,
                         input logic [7:0] exp4, input logic [7:0] exp1, input string tag);
    int lat4, lat1;
    logic [7:0] d4, d1;
    lat4 = -1; lat1 = -1; d4 = 8'h00; d1 = 8'h00;
    in_data = d; key = k; in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        in_valid = 1'b0;
        in_data  = ~d;
        key      = ~k;
        check({tag, "_busy"}, 32'(busy4), 32'd1);
        check({tag, "_in_ready_low"}, 32'(in_ready4), 32'd0);
      end
      if (c < 5) begin
        xs[c]  = u4.x;
        rks[c] = u4.rk;
      end
      if (out_valid4 && lat4 < 0) begin lat4 = c; d4 = out_data4; end
      if (out_valid1 && lat1 < 0) begin lat1 = c; d1 = out_data1; end
    end
    check({tag, "_lat4"}, 32'(lat4), 32'd4);
    check({tag, "_data4"}, 32'(d4), 32'(exp4));
    check({tag, "_lat1"}, 32'(lat1), 32'd1);
    check({tag, "_data1"}, 32'(d1), 32'(exp1));
    check({tag, "_idle_after"}, 32'(in_ready4), 32'd1);
  endtask

  initial begin
    logic [7:0] exp_x  [0:3];
    logic [7:0] exp_rk [0:3];
    int ev_cyc [0:1];
    logic [7:0] ev_dat [0:1];
    int nev;
    bit seen;
    exp_x  = '{8'hC6, 8'h8D, 8'h2E, 8'hFF};
    exp_rk = '{8'h01, 8'h0A, 8'h53, 8'h9E};

    // Reset held with in_valid high.
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h00; key = 8'h00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready4), 32'd0);
    check("rst_out_valid", 32'(out_valid4), 32'd0);
    check("rst_out_data", 32'(out_data4), 32'h00);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_out_valid1", 32'(out_valid1), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", 32'(in_ready4), 32'd1);
    check("rst_release_in_ready1", 32'(in_ready1), 32'd1);

    // Main vectors; the first also checks intermediate state.
    run_vec(8'h00, 8'h00, 8'h61, 8'hC7, "v0000");
    for (int r = 0; r < 4; r++) begin
      check($sformatf("x_round%0d", r), 32'(xs[r+1]), 32'(exp_x[r]));
      check($sformatf("rk_round%0d", r), 32'(rks[r+1]), 32'(exp_rk[r]));
    end
    run_vec(8'h53, 8'h00, 8'h6E, 8'hDA, "v5300");
    run_vec(8'h00, 8'hFF, 8'h88, 8'hD2, "v00ff");

    // Backpressure: hold ciphertext while out_ready is low.
    out_ready = 1'b0;
    in_data = 8'h00; key = 8'h00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = out_valid4;
    end
    check("bp_valid_seen", 32'(seen), 32'd1);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      key      = 8'(c * 37);
      in_data  = 8'(c * 11 + 5);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid4), 32'd1);
      check("bp_out_data", 32'(out_data4), 32'h61);
      check("bp_in_ready", 32'(in_ready4), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid4), 32'd0);
    check("bp_release_busy", 32'(busy4), 32'd0);
    check("bp_release_in_ready", 32'(in_ready4), 32'd1);
    repeat (2) @(negedge clk);

    // Reset two cycles after accept discards the byte.
    in_data = 8'h00; key = 8'h00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid4), 32'd0);
    check("mid_rst_busy", 32'(busy4), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready4), 32'd0);
    check("mid_rst_out_data", 32'(out_data4), 32'h00);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid4) seen = 1'b1;
    end
    check("mid_rst_no_valid", 32'(seen), 32'd0);
    run_vec(8'h00, 8'h00, 8'h61, 8'hC7, "after_rst");

    // Back-to-back with in_valid held high on the ROUNDS=4 instance.
    nev = 0;
    ev_cyc = '{-1, -1};
    ev_dat = '{8'h00, 8'h00};
    in_data = 8'h00; key = 8'h00; in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) in_data = 8'h53;
      if (c == 5) begin
        check("b2b_busy_gap", 32'(busy4), 32'd0);
        check("b2b_in_ready_gap", 32'(in_ready4), 32'd1);
      end
      if (c == 6) begin
        check("b2b_second_accept", 32'(busy4), 32'd1);
        in_valid = 1'b0;
      end
      if (out_valid4 && nev < 2) begin
        ev_cyc[nev] = c;
        ev_dat[nev] = out_data4;
        nev++;
      end
    end
    check("b2b_first_cycle", 32'(ev_cyc[0]), 32'd4);
    check("b2b_first_data", 32'(ev_dat[0]), 32'h61);
    check("b2b_second_cycle", 32'(ev_cyc[1]), 32'd10);
    check("b2b_second_data", 32'(ev_dat[1]), 32'h6E);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
